// File: rtl/and_unit_arbiter.sv
// and_unit_arbiter: shares one bitwise AND unit between NREQ requesters.
//
// Build option: ANDARB_FIXED_PRIO_EN
//   undefined (default) -> round-robin arbitration with a rotating pointer
//   defined             -> fixed priority, lowest set req index always wins
//
// Handshake: requester i raises req[i] with its operands on a_bus/b_bus and
// holds both until done[i]. req is sampled only while IDLE. A grant (gnt[i])
// is raised the cycle after sampling, done[i] pulses for exactly one cycle
// the cycle after that, together with result. Operands are latched at grant,
// so dropping req or changing operands after the grant has no effect. A req
// still high in the IDLE cycle that follows done is treated as a new request.
module and_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_bus,
  input  logic [NREQ*WIDTH-1:0]   b_bus,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [WIDTH-1:0]        result,
  output logic                    busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
`ifndef ANDARB_FIXED_PRIO_EN
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
`endif

  logic              found;
  logic [PW-1:0]     pick;
  logic [PW-1:0]     idx;
  logic [WIDTH-1:0]  a_sel;
  logic [WIDTH-1:0]  b_sel;

  // Arbiter: scan from the highest search offset down so the closest set
  // req bit (relative to the start point) is the last one written.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
`ifdef ANDARB_FIXED_PRIO_EN
      idx = PW'(k);
`else
      idx = PW'((int'(ptr_q) + k) % NREQ);
`endif
      if (req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Operand mux for the requester chosen by the arbiter.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == PW'(i)) begin
        a_sel = a_bus[i*WIDTH +: WIDTH];
        b_sel = b_bus[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and datapath update for the IDLE -> EXEC -> RESP cycle.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = done_q;
    result_d = result_q;
    a_d      = a_q;
    b_d      = b_q;
`ifndef ANDARB_FIXED_PRIO_EN
    ptr_d    = ptr_q;
    win_d    = win_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          a_d     = a_sel;
          b_d     = b_sel;
`ifndef ANDARB_FIXED_PRIO_EN
          win_d   = pick;
`endif
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = a_q & b_q;
        done_d   = gnt_q;
        state_d  = RESP;
      end
      RESP: begin
        done_d  = '0;
        gnt_d   = '0;
`ifndef ANDARB_FIXED_PRIO_EN
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
`endif
        state_d = IDLE;
      end
      default: begin
        done_d  = '0;
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset mid-operation drops everything without a done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
`ifndef ANDARB_FIXED_PRIO_EN
      ptr_q    <= '0;
      win_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      a_q      <= a_d;
      b_q      <= b_d;
`ifndef ANDARB_FIXED_PRIO_EN
      ptr_q    <= ptr_d;
      win_q    <= win_d;
`endif
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign result = result_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_and_unit_arbiter.sv
// Testbench for and_unit_arbiter (NREQ=4, WIDTH=8).
// Reference model: operation timeline keyed on the edge at which a request
// was accepted, with arbitration computed by plain modulo search.
module tb_and_unit_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*W-1:0]    a_bus;
  logic [NREQ*W-1:0]    b_bus;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic [W-1:0]         result;
  logic                 busy;

  int n_vec = 0;
  int n_err = 0;

  and_unit_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a_bus  (a_bus),
    .b_bus  (b_bus),
    .gnt    (gnt),
    .done   (done),
    .result (result),
    .busy   (busy)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    a_bus = '0;
    b_bus = '0;
  end

  // ---------------- reference model ----------------
  logic [W-1:0]    exp_q[$];
  int              edge_n  = 0;
  int              op_edge = -100;
  int              m_win   = 0;
  int              m_ptr   = 0;
  int              age;
  logic [NREQ-1:0] exp_gnt    = '0;
  logic [NREQ-1:0] exp_done   = '0;
  logic [W-1:0]    exp_result = '0;
  logic            exp_busy   = 1'b0;

  function automatic int pick_winner(logic [NREQ-1:0] r, int p);
    int start;
`ifdef ANDARB_FIXED_PRIO_EN
    start = 0;
`else
    start = p;
`endif
    for (int k = 0; k < NREQ; k++)
      if (r[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  always @(posedge clk) begin
    edge_n++;
    if (!rst_n) begin
      op_edge    = -100;
      m_ptr      = 0;
      exp_result = '0;
      exp_q.delete();
    end else if (edge_n - op_edge >= 3) begin
      if (req != '0) begin
        m_win   = pick_winner(req, m_ptr);
        op_edge = edge_n;
        exp_q.push_back(a_bus[m_win*W +: W] & b_bus[m_win*W +: W]);
      end
    end else if (edge_n - op_edge == 1) begin
      exp_result = exp_q.pop_front();
    end else if (edge_n - op_edge == 2) begin
      m_ptr = (m_win + 1) % NREQ;
    end
    age      = edge_n - op_edge;
    exp_gnt  = (age == 0 || age == 1) ? (NREQ'(1) << m_win) : '0;
    exp_done = (age == 1) ? (NREQ'(1) << m_win) : '0;
    exp_busy = (age == 0 || age == 1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] av, input logic [W-1:0] bv);
    a_bus[i*W +: W] = av;
    b_bus[i*W +: W] = bv;
  endtask

  task automatic settle();
    int c;
    req = '0;
    c = 0;
    while (busy !== 1'b0 && c < 10) begin
      tick();
      c++;
    end
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL settle_timeout busy got %b exp 0", busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b1111;
    a_bus = $urandom;
    b_bus = $urandom;
    tick();
    tick();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL reset_done got %b exp 0000", done); end
    n_vec++; if (result !== 8'h00) begin n_err++; $display("FAIL reset_result got %h exp 00", result); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL reset_first_grant got %b exp 0001", gnt); end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_single();
    settle();
    set_ops(2, 8'hF0, 8'h3C);
    req = 4'b0100;
    tick();
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt got %b exp 0100", gnt); end
    n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL single_early_done got %b exp 0000", done); end
    tick();
    n_vec++; if (done !== 4'b0100) begin n_err++; $display("FAIL single_done got %b exp 0100", done); end
    n_vec++; if (result !== 8'h30) begin n_err++; $display("FAIL single_result got %h exp 30", result); end
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt_at_done got %b exp 0100", gnt); end
    req = '0;
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_after got %b exp 0", busy); end
    n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL single_done_width got %b exp 0000", done); end
  endtask

  task automatic test_round_robin();
    int seen;
    int idx;
    int exp_idx;
    logic [W-1:0] av[NREQ];
    logic [W-1:0] bv[NREQ];
    rst_n = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      av[i] = W'($urandom_range(0, 255));
      bv[i] = W'($urandom_range(0, 255));
      set_ops(i, av[i], bv[i]);
    end
    req  = 4'b1111;
    seen = 0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (done !== 4'b0000) begin
        idx = -1;
        for (int i = 0; i < NREQ; i++) if (done[i]) idx = i;
`ifdef ANDARB_FIXED_PRIO_EN
        exp_idx = 0;
`else
        exp_idx = seen % NREQ;
`endif
        n_vec++; if (idx != exp_idx) begin n_err++; $display("FAIL rr_order got %0d exp %0d", idx, exp_idx); end
        n_vec++; if (c != 2 + 3 * seen) begin n_err++; $display("FAIL rr_interval got cycle %0d exp %0d", c, 2 + 3 * seen); end
        n_vec++; if (result !== (av[exp_idx] & bv[exp_idx])) begin n_err++; $display("FAIL rr_result got %h exp %h", result, av[exp_idx] & bv[exp_idx]); end
        seen++;
      end
    end
    n_vec++; if (seen != 5) begin n_err++; $display("FAIL rr_count got %0d exp 5", seen); end
    settle();
  endtask

  task automatic test_wrap();
    logic [NREQ-1:0] e1, e3;
`ifdef ANDARB_FIXED_PRIO_EN
    e1 = 4'b0001; e3 = 4'b0001;
`else
    e1 = 4'b1000; e3 = 4'b0010;
`endif
    rst_n = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
    req   = 4'b0100;
    tick();
    req = 4'b1001;
    tick();
    tick();
    tick();
    n_vec++; if (gnt !== e1) begin n_err++; $display("FAIL wrap_grant3 got %b exp %b", gnt, e1); end
    tick();
    tick();
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL wrap_grant0 got %b exp 0001", gnt); end
    req = 4'b0011;
    tick();
    tick();
    tick();
    n_vec++; if (gnt !== e3) begin n_err++; $display("FAIL wrap_ptr_after got %b exp %b", gnt, e3); end
    settle();
  endtask

  task automatic test_reset_mid_op();
    rst_n = 1'b0;
    req   = '0;
    tick();
    rst_n = 1'b1;
    req   = 4'b0100;
    tick();
    req = '0;
    tick();
    tick();
    set_ops(1, 8'hFF, 8'hFF);
    req = 4'b0010;
    tick();
    n_vec++; if (gnt !== 4'b0010) begin n_err++; $display("FAIL midrst_gnt got %b exp 0010", gnt); end
    rst_n = 1'b0;
    tick();
    n_vec++; if (gnt !== 4'b0000) begin n_err++; $display("FAIL midrst_gnt_clr got %b exp 0000", gnt); end
    n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL midrst_done got %b exp 0000", done); end
    n_vec++; if (result !== 8'h00) begin n_err++; $display("FAIL midrst_result got %h exp 00", result); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    req   = 4'b1111;
    tick();
    n_vec++; if (gnt !== 4'b0001) begin n_err++; $display("FAIL midrst_restart got %b exp 0001", gnt); end
    n_vec++; if (done !== 4'b0000) begin n_err++; $display("FAIL midrst_no_done got %b exp 0000", done); end
    settle();
  endtask

  task automatic test_dropped_req();
    logic [W-1:0] av, bv;
    settle();
    av = W'($urandom_range(1, 255));
    bv = W'($urandom_range(1, 255));
    set_ops(2, av, bv);
    req = 4'b0100;
    tick();
    n_vec++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL drop_gnt got %b exp 0100", gnt); end
    req = '0;
    set_ops(2, ~av, ~bv);
    tick();
    n_vec++; if (done !== 4'b0100) begin n_err++; $display("FAIL drop_done got %b exp 0100", done); end
    n_vec++; if (result !== (av & bv)) begin n_err++; $display("FAIL drop_result got %h exp %h", result, av & bv); end
    tick();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_busy got %b exp 0", busy); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      tick();
      n_vec++; if (gnt !== exp_gnt) begin n_err++; $display("FAIL rand_gnt cyc %0d got %b exp %b", c, gnt, exp_gnt); end
      n_vec++; if (done !== exp_done) begin n_err++; $display("FAIL rand_done cyc %0d got %b exp %b", c, done, exp_done); end
      n_vec++; if (busy !== exp_busy) begin n_err++; $display("FAIL rand_busy cyc %0d got %b exp %b", c, busy, exp_busy); end
      n_vec++; if (result !== exp_result) begin n_err++; $display("FAIL rand_result cyc %0d got %h exp %h", c, result, exp_result); end
      rst_n = ($urandom_range(0, 63) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (exp_done[i]) begin
            if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
            else set_ops(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
          end
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          set_ops(i, W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        end
      end
    end
    rst_n = 1'b1;
    settle();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_reset_mid_op();
    test_dropped_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
